// File: rtl/froge_pkg.sv
// Shared constants and types for the game's sprite movers (cars, logs, frog).
package froge_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 24;

    // Signed horizontal position: sprites may sit partly off the left edge.
    typedef logic signed [10:0] xpos_t;

    // Palette index that the colour mapper treats as "no pixel".
    localparam logic [7:0] TRANSPARENT_IDX = 8'd0;

    // First pixel-pipeline stage: sprite-local coordinates of the winning car.
    typedef struct packed {
        logic       inbox;
        logic [5:0] dx;
        logic [5:0] dy;
    } s1_t;

    localparam s1_t S1_IDLE = '{inbox: 1'b0, dx: 6'd0, dy: 6'd0};

endpackage

// File: rtl/frame_tick_sync.sv
// Brings a vsync-derived level into the logic clock domain and emits a
// single-cycle pulse on each rising edge. Shared by all sprite movers.
module frame_tick_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_tick
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two-flop synchroniser followed by a history flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_level;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // History is cleared to 0, so a level already high after reset still counts as an edge.
    assign o_tick = r_sync & ~r_prev;

endmodule

// File: rtl/othercar_lane_engine.sv
// One lane of right-moving cars: per-frame motion, scan-position to sprite
// ROM address mapping, registered car pixel output and frog overlap flag.
module othercar_lane_engine #(
    parameter int NUM_CARS = 3,
    parameter int LANE_Y   = 240,
    parameter int SPEED    = 2,
    parameter int SPACING  = 224,
    parameter int SCREEN_W = froge_pkg::SCREEN_W,
    parameter int SPRITE_W = froge_pkg::SPRITE_W,
    parameter int SPRITE_H = froge_pkg::SPRITE_H
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       freeze,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    input  logic [7:0] rom_data,
    output logic [5:0] DX,
    output logic [5:0] DY,
    output logic       car_on,
    output logic [7:0] car_idx,
    output logic       collide
);

    import froge_pkg::*;

    // Constants pre-sized to the arithmetic widths they are compared against.
    localparam logic signed [11:0] C_WRAP_AT = 12'(SCREEN_W);
    localparam logic signed [11:0] C_WRAP_BY = 12'(SCREEN_W + SPRITE_W);
    localparam logic signed [11:0] C_SPEED   = 12'(SPEED);
    localparam logic signed [10:0] C_SW11    = 11'(SPRITE_W);
    localparam logic signed [10:0] C_SH11    = 11'(SPRITE_H);
    localparam logic signed [10:0] C_LANE11  = 11'(LANE_Y);
    localparam logic signed [11:0] C_SW12    = 12'(SPRITE_W);
    localparam logic signed [11:0] C_SH12    = 12'(SPRITE_H);
    localparam logic signed [11:0] C_LANE12  = 12'(LANE_Y);

    logic                w_tick;
    logic [NUM_CARS-1:0] w_hit;
    logic [NUM_CARS-1:0] w_overlap;
    logic [5:0]          w_rx_lo [NUM_CARS];
    logic signed [10:0]  w_ry;
    logic                w_ry_ok;
    logic signed [11:0]  w_fx;
    logic signed [11:0]  w_fy;
    logic                w_fy_ok;
    s1_t                 w_s1;
    s1_t                 r_s1;
    logic [7:0]          r_idx;
    logic                r_on;
    logic                r_collide;

    frame_tick_sync u_frame_sync (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_level (frame_clk),
        .o_tick  (w_tick)
    );

    // Row offset into the lane is common to every car.
    assign w_ry    = $signed({1'b0, DrawY}) - C_LANE11;
    assign w_ry_ok = !w_ry[10] && (w_ry < C_SH11);

    // Frog box extents widened to 12 bits so sums never overflow.
    assign w_fx    = $signed({2'b00, frog_x});
    assign w_fy    = $signed({2'b00, frog_y});
    assign w_fy_ok = (w_fy < C_LANE12 + C_SH12) && (C_LANE12 < w_fy + C_SH12);

    for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
        localparam xpos_t C_INIT = 11'(gi * SPACING);

        xpos_t              r_car_x;
        logic signed [11:0] w_sum;
        logic signed [11:0] w_wrapped;
        xpos_t              w_next;
        xpos_t              w_rx;
        logic signed [11:0] w_cx;

        // Advance by SPEED; past the right edge the car re-enters one sprite-width left of 0.
        assign w_sum     = $signed({r_car_x[10], r_car_x}) + C_SPEED;
        assign w_wrapped = w_sum - C_WRAP_BY;
        assign w_next    = (w_sum >= C_WRAP_AT) ? w_wrapped[10:0] : w_sum[10:0];

        // Car position: restarts at its slot, moves only on unfrozen frame ticks.
        always_ff @(posedge Clk) begin
            if (!Reset) begin
                r_car_x <= C_INIT;
            end else if (w_tick && !freeze) begin
                r_car_x <= w_next;
            end
        end

        // Sprite-local column of the scan position relative to this car.
        assign w_rx         = $signed({1'b0, DrawX}) - r_car_x;
        assign w_hit[gi]    = !w_rx[10] && (w_rx < C_SW11) && w_ry_ok;
        assign w_rx_lo[gi]  = w_rx[5:0];

        // Horizontal box overlap with the frog; vertical test is shared.
        assign w_cx          = $signed({r_car_x[10], r_car_x});
        assign w_overlap[gi] = (w_fx < w_cx + C_SW12) && (w_cx < w_fx + C_SW12);
    end

    // Pick the lowest-index car covering the scan position.
    always_comb begin
        w_s1 = S1_IDLE;
        for (int unsigned k = 0; k < NUM_CARS; k++) begin
            if (w_hit[k] && !w_s1.inbox) begin
                w_s1.inbox = 1'b1;
                w_s1.dx    = w_rx_lo[k];
                w_s1.dy    = w_ry[5:0];
            end
        end
    end

    // Stage 1: register ROM address and in-box flag.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_s1 <= S1_IDLE;
        end else begin
            r_s1 <= w_s1;
        end
    end

    // Stage 2: register the ROM palette index; index 0 is see-through.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_idx <= TRANSPARENT_IDX;
            r_on  <= 1'b0;
        end else begin
            r_idx <= r_s1.inbox ? rom_data : TRANSPARENT_IDX;
            r_on  <= r_s1.inbox && (rom_data != TRANSPARENT_IDX);
        end
    end

    // Collision flag: any car box overlapping the frog box this cycle.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_collide <= 1'b0;
        end else begin
            r_collide <= (|w_overlap) && w_fy_ok;
        end
    end

    assign DX      = r_s1.dx;
    assign DY      = r_s1.dy;
    assign car_idx = r_idx;
    assign car_on  = r_on;
    assign collide = r_collide;

endmodule

// File: tb/tb_othercar_lane_engine.sv
// Directed bench for othercar_lane_engine with a behavioural car ROM.
module tb_othercar_lane_engine;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       freeze;
    logic [9:0] DrawX, DrawY, frog_x, frog_y;
    logic [7:0] rom_data;
    logic [5:0] DX, DY;
    logic       car_on;
    logic [7:0] car_idx;
    logic       collide;

    int ntests = 0;
    int nfail  = 0;
    int mcar [3];

    othercar_lane_engine #(
        .NUM_CARS (3),
        .LANE_Y   (240),
        .SPEED    (2),
        .SPACING  (224)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .freeze    (freeze),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .frog_x    (frog_x),
        .frog_y    (frog_y),
        .rom_data  (rom_data),
        .DX        (DX),
        .DY        (DY),
        .car_on    (car_on),
        .car_idx   (car_idx),
        .collide   (collide)
    );

    always #5 Clk = ~Clk;

    // Car ROM stand-in: transparent on column 0 and row 0.
    function automatic logic [7:0] rom_f(input logic [5:0] dx, input logic [5:0] dy);
        if (dx == 6'd0 || dy == 6'd0) return 8'd0;
        return 8'(int'(dx) + 2 * int'(dy) + 2);
    endfunction

    assign rom_data = rom_f(DX, DY);

    typedef struct {
        int x, y, fx, fy;
        int e_dx, e_dy, e_idx, e_on, e_col;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mcar[i] = i * 224;
    endtask

    task automatic model_tick();
        for (int i = 0; i < 3; i++) begin
            int s;
            s = mcar[i] + 2;
            if (s >= 640) s = s - 672;
            mcar[i] = s;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic pulse();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        if (!freeze) model_tick();
    endtask

    // Drive scan and frog position, let both pipeline stages settle, compare to the model.
    task automatic check_pix(input string tag, input int x, input int y, input int fx, input int fy);
        int inb, edx, edy, eidx, ecol, rx, ry;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); frog_x = 10'(fx); frog_y = 10'(fy);
        repeat (3) @(negedge Clk);
        inb = 0; edx = 0; edy = 0; ecol = 0;
        ry = y - 240;
        for (int i = 0; i < 3; i++) begin
            rx = x - mcar[i];
            if (inb == 0 && rx >= 0 && rx < 32 && ry >= 0 && ry < 24) begin
                inb = 1; edx = rx; edy = ry;
            end
            if (fx < mcar[i] + 32 && mcar[i] < fx + 32 && fy < 264 && 240 < fy + 24) ecol = 1;
        end
        eidx = inb ? int'(rom_f(6'(edx), 6'(edy))) : 0;
        chk({tag, ".DX"},      int'(DX),      edx);
        chk({tag, ".DY"},      int'(DY),      edy);
        chk({tag, ".car_idx"}, int'(car_idx), eidx);
        chk({tag, ".car_on"},  int'(car_on),  (eidx != 0) ? 1 : 0);
        chk({tag, ".collide"}, int'(collide), ecol);
    endtask

    initial begin
        // Hand-computed vectors with cars at 0, 224, 448 and LANE_Y = 240.
        vt[0] = '{5,   247, 600, 0,   5,  7,  21, 1, 0};
        vt[1] = '{0,   243, 300, 240, 0,  3,  0,  0, 0};
        vt[2] = '{230, 250, 250, 230, 6,  10, 28, 1, 1};
        vt[3] = '{479, 263, 0,   217, 31, 23, 79, 1, 1};
        vt[4] = '{480, 250, 0,   216, 0,  0,  0,  0, 0};
        vt[5] = '{10,  264, 470, 263, 0,  0,  0,  0, 1};
        vt[6] = '{10,  239, 480, 250, 0,  0,  0,  0, 0};
        vt[7] = '{40,  250, 416, 250, 0,  0,  0,  0, 0};
        vt[8] = '{31,  240, 417, 240, 31, 0,  0,  0, 1};
        vt[9] = '{224, 241, 0,   240, 0,  1,  0,  0, 1};

        Reset = 1'b0; frame_clk = 1'b0; freeze = 1'b0;
        DrawX = 10'd5; DrawY = 10'd247; frog_x = 10'd600; frog_y = 10'd0;
        model_reset();

        // Reset state, sampled while Reset is still low.
        repeat (2) @(negedge Clk);
        chk("rst.DX",      int'(DX),      0);
        chk("rst.DY",      int'(DY),      0);
        chk("rst.car_on",  int'(car_on),  0);
        chk("rst.car_idx", int'(car_idx), 0);
        chk("rst.collide", int'(collide), 0);
        Reset = 1'b1;

        // Static table at reset positions.
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            DrawX = 10'(vt[i].x); DrawY = 10'(vt[i].y);
            frog_x = 10'(vt[i].fx); frog_y = 10'(vt[i].fy);
            @(negedge Clk);
            chk($sformatf("v%0d.DX_lat1", i), int'(DX), vt[i].e_dx);
            chk($sformatf("v%0d.DY_lat1", i), int'(DY), vt[i].e_dy);
            repeat (2) @(negedge Clk);
            chk($sformatf("v%0d.car_idx", i), int'(car_idx), vt[i].e_idx);
            chk($sformatf("v%0d.car_on", i),  int'(car_on),  vt[i].e_on);
            chk($sformatf("v%0d.collide", i), int'(collide), vt[i].e_col);
        end

        // One tick: car 0 now at 2.
        pulse();
        check_pix("tick1", 7, 247, 600, 0);
        chk("tick1.idx_hand", int'(car_idx), 21);

        // Frozen ticks are dropped, not replayed after unfreezing.
        freeze = 1'b1;
        repeat (5) pulse();
        freeze = 1'b0;
        check_pix("frz_a", 7, 247, 600, 0);
        check_pix("frz_b", 231, 247, 600, 0);
        repeat (10) @(negedge Clk);
        check_pix("frz_c", 7, 247, 600, 0);
        pulse();
        check_pix("unfrz", 9, 247, 600, 0);
        chk("unfrz.DX_hand", int'(DX), 5);

        // Collision edge: car 0 at 168 (touching only), then 170 (overlap).
        do_reset();
        repeat (84) pulse();
        check_pix("col168", 600, 0, 200, 240);
        chk("col168.hand", int'(collide), 0);
        pulse();
        check_pix("col170", 600, 0, 200, 240);
        chk("col170.hand", int'(collide), 1);
        check_pix("col_ybelow", 600, 0, 200, 264);
        chk("col_ybelow.hand", int'(collide), 0);

        // Wrap: drive car 0 to 638, then 640 -> -32, then -30.
        repeat (234) pulse();
        check_pix("at638", 639, 250, 0, 0);
        chk("at638.DX_hand", int'(DX), 1);
        pulse();
        check_pix("wrap1", 0, 245, 0, 240);
        check_pix("wrap1_left", 31, 245, 0, 240);
        pulse();
        check_pix("wrap2", 0, 245, 0, 240);
        chk("wrap2.DX_hand", int'(DX), 30);
        chk("wrap2.on_hand", int'(car_on), 1);

        // Reset mid-line with a car pixel showing.
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrst.car_on", int'(car_on), 0);
        chk("midrst.DX",     int'(DX),     0);
        chk("midrst.collide", int'(collide), 0);
        Reset = 1'b1;
        model_reset();
        check_pix("postrst", 5, 247, 600, 0);
        chk("postrst.idx_hand", int'(car_idx), 21);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
